// File: rtl/tpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tpu_seq_ctrl
// Sequencer for one systolic-array matrix pass. It shares the SRAM port with
// the host. While idle, host writes go straight through to the SRAM. After a
// rising edge on tpu_start_i, the sequencer takes the port and runs one pass:
//   1. Read the weight matrix into the array.
//   2. Read the data matrix into the array.
//   3. Wait for the array skew to drain.
//   4. Write the result matrix back to SRAM.
//
// Optional build macro: TPU_SEQ_CTRL_PERF_EN
//   When defined, perf_cycles_o reports the busy-cycle count of the last pass.
//   When undefined, perf_cycles_o is tied to zero.
//
// Ports
//   clk             clock, rising edge
//   rst_n           asynchronous active-low reset
//   tpu_start_i     start request, rising-edge sensitive
//   host_wr_en_i    host SRAM write strobe
//   host_wr_addr_i  host SRAM write address
//   sram_addr_o     SRAM address (host in IDLE, controller otherwise)
//   sram_we_o       SRAM write enable
//   sram_re_o       SRAM read enable (read data valid one cycle later)
//   w_load_o        array: load weight word (one cycle after its read)
//   a_valid_o       array: data word valid (one cycle after its read)
//   elem_idx_o      element index for w_load_o / a_valid_o / res_rd_en_o
//   res_rd_en_o     array: drive result word elem_idx_o onto SRAM write data
//   busy_o          high in every state except IDLE
//   done_o          one-cycle pulse at the end of a pass
//   host_wr_err_o   one-cycle pulse: a host write was rejected while busy
//   perf_cycles_o   busy-cycle count of the last pass
// -----------------------------------------------------------------------------
module tpu_seq_ctrl #(
  parameter int ARRAY_SIZE  = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_BASE   = 0,
  parameter int WEIGHT_BASE = 16,
  parameter int RESULT_BASE = 32,
  localparam int IDX_W      = $clog2(ARRAY_SIZE * ARRAY_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tpu_start_i,
  input  logic              host_wr_en_i,
  input  logic [ADDR_W-1:0] host_wr_addr_i,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_we_o,
  output logic              sram_re_o,
  output logic              w_load_o,
  output logic              a_valid_o,
  output logic [IDX_W-1:0]  elem_idx_o,
  output logic              res_rd_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              host_wr_err_o,
  output logic [31:0]       perf_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_WB     = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam logic [IDX_W-1:0]  CNT_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0]  CNT_MAT_END = IDX_W'(ARRAY_SIZE * ARRAY_SIZE - 1);
  // The drain window covers the last a_valid beat plus 2N-1 cycles of array skew.
  localparam logic [IDX_W-1:0]  CNT_DRN_END = IDX_W'(2 * ARRAY_SIZE - 1);
  localparam logic [ADDR_W-1:0] W_BASE      = ADDR_W'(WEIGHT_BASE);
  localparam logic [ADDR_W-1:0] D_BASE      = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W-1:0] R_BASE      = ADDR_W'(RESULT_BASE);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q;
  logic              start_q;
  logic              w_load_q, a_valid_q, err_q;
  logic              start_edge;
  logic [ADDR_W-1:0] sram_addr_c;
  logic              sram_we_c, sram_re_c, res_rd_en_c;

  assign start_edge = tpu_start_i & ~start_q;

  // Next-state and combinational SRAM/array controls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sram_addr_c = {ADDR_W{1'b0}};
    sram_we_c   = 1'b0;
    sram_re_c   = 1'b0;
    res_rd_en_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Host owns the port; this is a same-cycle pass-through.
        sram_addr_c = host_wr_addr_i;
        sram_we_c   = host_wr_en_i;
        if (start_edge) begin
          state_d = S_LOAD_W;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        sram_re_c   = 1'b1;
        sram_addr_c = W_BASE + ADDR_W'(cnt_q);
        if (cnt_q == CNT_MAT_END) begin
          state_d = S_FEED;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FEED: begin
        sram_re_c   = 1'b1;
        sram_addr_c = D_BASE + ADDR_W'(cnt_q);
        if (cnt_q == CNT_MAT_END) begin
          state_d = S_DRAIN;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_DRN_END) begin
          state_d = S_WB;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WB: begin
        sram_we_c   = 1'b1;
        res_rd_en_c = 1'b1;
        sram_addr_c = R_BASE + ADDR_W'(cnt_q);
        if (cnt_q == CNT_MAT_END) begin
          state_d = S_DONE;
          cnt_d   = {IDX_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, counter, start-edge history and the delayed array strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {IDX_W{1'b0}};
      start_q   <= 1'b0;
      w_load_q  <= 1'b0;
      a_valid_q <= 1'b0;
      idx_q     <= {IDX_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= tpu_start_i;
      // Read data arrives one cycle after sram_re, so the strobes lag the read.
      w_load_q  <= (state_q == S_LOAD_W);
      a_valid_q <= (state_q == S_FEED);
      // Track WB too, so elem_idx keeps the last index once the pass ends.
      if ((state_q == S_LOAD_W) || (state_q == S_FEED) || (state_q == S_WB)) begin
        idx_q <= cnt_q;
      end else begin
        idx_q <= idx_q;
      end
      err_q     <= (state_q != S_IDLE) & host_wr_en_i;
    end
  end

  assign sram_addr_o   = sram_addr_c;
  assign sram_we_o     = sram_we_c;
  assign sram_re_o     = sram_re_c;
  assign res_rd_en_o   = res_rd_en_c;
  assign w_load_o      = w_load_q;
  assign a_valid_o     = a_valid_q;
  // During write-back the index follows the live counter, in step with res_rd_en.
  assign elem_idx_o    = (state_q == S_WB) ? cnt_q : idx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign host_wr_err_o = err_q;

`ifdef TPU_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d, perf_q;

  // Busy-cycle counter: cleared by an accepted start and saturating at all-ones.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (state_q == S_IDLE) begin
      if (start_edge) begin
        perf_cnt_d = 32'd0;
      end else begin
        perf_cnt_d = perf_cnt_q;
      end
    end else if (perf_cnt_q != 32'hFFFF_FFFF) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // Snapshot in DONE includes the DONE cycle itself, so the next-count value is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt_q <= 32'd0;
      perf_q     <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
      if (state_q == S_DONE) begin
        perf_q <= perf_cnt_d;
      end else begin
        perf_q <= perf_q;
      end
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl (default parameters, N=4).
// A high-level pass model turns each accepted start into timed expected events.
// A negedge monitor pops these events as the DUT presents them.
module tb_tpu_seq_ctrl;

  localparam int N    = 4;
  localparam int NN   = N * N;
  localparam int PLEN = 3 * NN + 2 * N + 1;
`ifdef TPU_SEQ_CTRL_PERF_EN
  localparam int PERF_EXP = PLEN;
`else
  localparam int PERF_EXP = 0;
`endif

  typedef struct {
    int cyc;
    int val;
    int idx;
    bit wb;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tpu_start = 1'b0;
  logic        host_wr_en = 1'b0;
  logic [9:0]  host_wr_addr = 10'd0;
  logic [9:0]  sram_addr;
  logic        sram_we, sram_re, w_load, a_valid, res_rd_en, busy, done, host_wr_err;
  logic [3:0]  elem_idx;
  logic [31:0] perf_cycles;

  tpu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tpu_start_i(tpu_start),
    .host_wr_en_i(host_wr_en), .host_wr_addr_i(host_wr_addr),
    .sram_addr_o(sram_addr), .sram_we_o(sram_we), .sram_re_o(sram_re),
    .w_load_o(w_load), .a_valid_o(a_valid), .elem_idx_o(elem_idx),
    .res_rd_en_o(res_rd_en), .busy_o(busy), .done_o(done),
    .host_wr_err_o(host_wr_err), .perf_cycles_o(perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_pass = 0;
  int  n_total = 0;
  bit  mon_en = 1'b0;
  bit  prev_start = 1'b0;
  int  busy_lo = 1;
  int  pass_end = 0;
  int  perf_upd_cyc = -1;
  int  exp_perf = 0;
  ev_t q_rd[$], q_wl[$], q_av[$], q_wr[$], q_err[$], q_done[$];

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic ev_t mk(input int c, input int v, input int i, input bit wb);
    ev_t e;
    e.cyc = c; e.val = v; e.idx = i; e.wb = wb;
    return e;
  endfunction

  // Reference model: idle means the current cycle lies beyond the last pass.
  task automatic model(input bit start, input bit we, input int addr);
    bit idle;
    bit edge_s;
    int t;
    idle   = (cyc > pass_end);
    edge_s = start && !prev_start;
    prev_start = start;
    if (we) begin
      if (idle) q_wr.push_back(mk(cyc, addr, 0, 1'b0));
      else      q_err.push_back(mk(cyc + 1, 0, 0, 1'b0));
    end
    if (edge_s && idle) begin
      t = cyc;
      busy_lo  = t + 1;
      pass_end = t + PLEN;
      perf_upd_cyc = t + PLEN + 1;
      for (int k = 0; k < NN; k++) begin
        q_rd.push_back(mk(t + 1 + k, 16 + k, k, 1'b0));
        q_wl.push_back(mk(t + 2 + k, 0, k, 1'b0));
      end
      for (int k = 0; k < NN; k++) begin
        q_rd.push_back(mk(t + 1 + NN + k, 0 + k, k, 1'b0));
        q_av.push_back(mk(t + 2 + NN + k, 0, k, 1'b0));
      end
      for (int k = 0; k < NN; k++)
        q_wr.push_back(mk(t + 1 + 2 * NN + 2 * N + k, 32 + k, k, 1'b1));
      q_done.push_back(mk(t + PLEN, 0, 0, 1'b0));
    end
  endtask

  task automatic drive(input bit start, input bit we, input int addr);
    @(posedge clk);
    #1;
    tpu_start    = start;
    host_wr_en   = we;
    host_wr_addr = addr[9:0];
    model(start, we, addr);
  endtask

  task automatic check_all_zero(input string tag);
    check(sram_addr === 10'd0, {tag, "_sram_addr"}, sram_addr, 0);
    check(sram_we === 1'b0, {tag, "_sram_we"}, sram_we, 0);
    check(sram_re === 1'b0, {tag, "_sram_re"}, sram_re, 0);
    check(w_load === 1'b0, {tag, "_w_load"}, w_load, 0);
    check(a_valid === 1'b0, {tag, "_a_valid"}, a_valid, 0);
    check(elem_idx === 4'd0, {tag, "_elem_idx"}, elem_idx, 0);
    check(res_rd_en === 1'b0, {tag, "_res_rd_en"}, res_rd_en, 0);
    check(busy === 1'b0, {tag, "_busy"}, busy, 0);
    check(done === 1'b0, {tag, "_done"}, done, 0);
    check(host_wr_err === 1'b0, {tag, "_host_wr_err"}, host_wr_err, 0);
    check(perf_cycles === 32'd0, {tag, "_perf_cycles"}, perf_cycles, 0);
  endtask

  // Asserts reset now, checks outputs, clears the model, releases after 'hold' edges.
  task automatic apply_reset(input string tag, input int hold);
    mon_en = 1'b0;
    tpu_start = 1'b0; host_wr_en = 1'b0; host_wr_addr = 10'd0;
    rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    q_rd.delete(); q_wl.delete(); q_av.delete(); q_wr.delete(); q_err.delete(); q_done.delete();
    busy_lo = 1; pass_end = 0; perf_upd_cyc = -1; exp_perf = 0; prev_start = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares every DUT-presented event against the scoreboard queues.
  always @(negedge clk) begin
    ev_t e;
    bit  exp_busy;
    if (mon_en) begin
      exp_busy = (cyc >= busy_lo) && (cyc <= pass_end);
      if (cyc == perf_upd_cyc) exp_perf = PERF_EXP;
      check(busy === exp_busy, "busy", busy, exp_busy);
      check(perf_cycles === 32'(exp_perf), "perf_cycles", perf_cycles, exp_perf);
      if (sram_re) begin
        if (q_rd.size() == 0) check(1'b0, "unexpected_read", sram_addr, -1);
        else begin
          e = q_rd.pop_front();
          check(sram_addr == 10'(e.val), "read_addr", sram_addr, e.val);
          check(cyc == e.cyc, "read_cycle", cyc, e.cyc);
        end
      end
      if (w_load) begin
        if (q_wl.size() == 0) check(1'b0, "unexpected_w_load", elem_idx, -1);
        else begin
          e = q_wl.pop_front();
          check(elem_idx == 4'(e.idx), "w_load_idx", elem_idx, e.idx);
          check(cyc == e.cyc, "w_load_cycle", cyc, e.cyc);
        end
      end
      if (a_valid) begin
        if (q_av.size() == 0) check(1'b0, "unexpected_a_valid", elem_idx, -1);
        else begin
          e = q_av.pop_front();
          check(elem_idx == 4'(e.idx), "a_valid_idx", elem_idx, e.idx);
          check(cyc == e.cyc, "a_valid_cycle", cyc, e.cyc);
        end
      end
      if (sram_we) begin
        if (q_wr.size() == 0) check(1'b0, "unexpected_write", sram_addr, -1);
        else begin
          e = q_wr.pop_front();
          check(sram_addr == 10'(e.val), "write_addr", sram_addr, e.val);
          check(cyc == e.cyc, "write_cycle", cyc, e.cyc);
          check(res_rd_en === e.wb, "res_rd_en", res_rd_en, e.wb);
          if (e.wb) check(elem_idx == 4'(e.idx), "wb_idx", elem_idx, e.idx);
        end
      end else if (res_rd_en) begin
        check(1'b0, "res_rd_en_without_we", res_rd_en, 0);
      end
      if (host_wr_err) begin
        if (q_err.size() == 0) check(1'b0, "unexpected_host_wr_err", cyc, -1);
        else begin
          e = q_err.pop_front();
          check(cyc == e.cyc, "host_wr_err_cycle", cyc, e.cyc);
        end
      end
      if (done) begin
        if (q_done.size() == 0) check(1'b0, "unexpected_done", cyc, -1);
        else begin
          e = q_done.pop_front();
          check(cyc == e.cyc, "done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    bit st;
    // T1: reset values, then a same-cycle host write pass-through.
    repeat (3) @(posedge clk);
    apply_reset("reset", 2);
    drive(1'b0, 1'b1, 5);
    #1;
    check(sram_we === 1'b1, "t1_sram_we", sram_we, 1);
    check(sram_addr === 10'd5, "t1_sram_addr", sram_addr, 5);
    for (int i = 0; i < 8; i++) drive(1'b0, ($urandom_range(0, 1) == 1), $urandom_range(0, 1023));

    // T2/T4: nominal pass with random host traffic (forwarded on the start cycle, rejected while busy).
    drive(1'b1, 1'b1, $urandom_range(0, 1023));
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 70; i++) drive(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1023));

    // T3: start held high gives one pass; a fresh edge later gives a second.
    for (int i = 0; i < 1000; i++) drive(1'b1, ($urandom_range(0, 7) == 0), $urandom_range(0, 1023));
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 0);
    for (int i = 0; i < 70; i++) drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 0);

    // T5: reset in DRAIN aborts the pass; the next pass runs in full.
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 35; i++) drive(1'b0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1023));
    @(posedge clk);
    #1;
    apply_reset("drain_reset", 3);
    drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 65; i++) drive(1'b0, 1'b0, 0);

    // Randomized start toggling and host traffic.
    st = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) st = ~st;
      drive(st, ($urandom_range(0, 3) == 0), $urandom_range(0, 1023));
    end
    for (int i = 0; i < 80; i++) drive(1'b0, 1'b0, 0);

    @(posedge clk);
    #1;
    check(q_rd.size() == 0, "pending_reads", q_rd.size(), 0);
    check(q_wl.size() == 0, "pending_w_load", q_wl.size(), 0);
    check(q_av.size() == 0, "pending_a_valid", q_av.size(), 0);
    check(q_wr.size() == 0, "pending_writes", q_wr.size(), 0);
    check(q_err.size() == 0, "pending_host_wr_err", q_err.size(), 0);
    check(q_done.size() == 0, "pending_done", q_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
